info_fdsti_blk_cmd_gen: RTL and testbench
=========================================

Name: info_fdsti_blk_cmd_gen

Overview:
Downstream consumer of the per-target info FIFOs, one FIFO per target lane. Each entry is packed {FDSSI, SSI, STI, LEN}. The block round-robin arbitrates across the 2**O_TAM_WIDTH target lanes and pops one entry at a time. It expands each entry into LEN sequential block-move commands carrying source/target block addresses. It signals drain completion once upstream input has finished and all lanes are idle and empty.

Parameters:
O_TAM_WIDTH, 2, log2 of target lane count; T = 2**O_TAM_WIDTH
I_FDSSI_WIDTH, 12, source-lane index field width
I_SSI_WIDTH, 8, source segment index width
I_STI_WIDTH, 8, target segment index width
LWIDTH, 32, block-count (LEN) field width
AWIDTH, 32, output block address width
SEG_SHIFT, 16, log2 blocks per segment; segment base = index << SEG_SHIFT
E_WIDTH, I_FDSSI_WIDTH+I_SSI_WIDTH+I_STI_WIDTH+LWIDTH, entry width (derived)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
s_info  input  E_WIDTH*T  lane j occupies bits [j*E_WIDTH +: E_WIDTH]; MSB→LSB {FDSSI, SSI, STI, LEN}
s_info_valid  input  T  per-lane entry valid (FIFO m_axis_tvalid)
s_info_ready  output  T  per-lane pop (FIFO m_axis_tready); at most one bit high
in_finish  input  1  pulse: upstream input complete (sticky-captured)
cmd_valid  output  1  command beat valid
cmd_ready  input  1  downstream accepts beat
cmd_fdssi  output  I_FDSSI_WIDTH  FDSSI of current entry
cmd_tlane  output  O_TAM_WIDTH  target lane the entry came from
cmd_src  output  AWIDTH  source block address
cmd_dst  output  AWIDTH  target block address
cmd_last  output  1  final beat of entry
drain_done  output  1  all work drained

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; finish flag 0; beat offset 0.
- finish_r: set on in_finish, cleared only by rst.
- FSM IDLE:
  - Grant the first lane with s_info_valid=1, searching from rr pointer upward, mod T.
  - s_info_ready[g]=1 combinationally in the same cycle; entry latched on that handshake.
  - rr pointer <= (g+1) mod T.
  - LEN≠0 → RUN. LEN=0 → entry dropped, no beat, stay IDLE.
  - No valid lanes → remain IDLE.
- FSM RUN:
  - cmd_valid=1 starting the cycle after the pop (latency 1).
  - cmd_src = ((SSI<<SEG_SHIFT)+off) mod 2**AWIDTH; cmd_dst = ((STI<<SEG_SHIFT)+off) mod 2**AWIDTH.
  - cmd_last = (off == LEN-1).
  - All cmd_* fields are registered and held stable while cmd_valid && !cmd_ready.
  - off increments only on cmd_valid&&cmd_ready.
  - On handshake with cmd_last: cmd_valid<=0, off<=0, → IDLE. The next pop occurs at the earliest in the following cycle, giving a one-cycle bubble between entries.
- s_info_ready is 0 in RUN; exactly one entry is in flight.
- off is LWIDTH bits; LEN = 2**LWIDTH-1 must produce exactly that many beats with no wrap of off.
- drain_done = finish_r && state==IDLE && s_info_valid==0, registered (1-cycle lag). It drops again if new valid appears.
- in_finish arriving mid-RUN: no effect on the current entry; drain_done waits for drain.
- rst mid-RUN: immediate abort, outputs to 0; the partially sent entry is lost and is not re-requested.

Test Plan:
1. Lane 2 entry {FDSSI=5, SSI=1, STI=3, LEN=3}, cmd_ready=1 → pop cycle N; beats N+1..N+3 with src 0x10000/0x10001/0x10002, dst 0x30000..0x30002, tlane=2, fdssi=5; last only on 3rd beat.
2. Lanes 0,1,3 valid with LEN=1 each, continuously → grant order 0,1,3,0…; one beat per entry; a bubble cycle between entries.
3. LEN=0 on lane 1 → s_info_ready[1] pulses once; no cmd_valid; block returns to IDLE.
4. cmd_ready toggled 0/1 randomly during LEN=4 → exactly 4 handshakes; fields stable while stalled; offsets 0..3 in order.
5. in_finish pulsed during RUN of LEN=2, FIFOs then empty → drain_done=0 until last handshake, then 1 one cycle after IDLE is reached.
6. rst asserted mid-entry (after beat 1 of LEN=5) → cmd_valid=0 asynchronously; after release, the next entry starts at off=0 with rr pointer 0.

Source files
------------

// File: rtl/info_fdsti_blk_cmd_gen.sv
// ---------------------------------------------------------------------------
// info_fdsti_blk_cmd_gen
//
// Drains the per-target-lane info FIFOs. Lanes are served round-robin, one
// entry at a time. Each entry {FDSSI, SSI, STI, LEN} expands into LEN
// block-move beats whose source/target addresses walk up from the segment
// base addresses (index << SEG_SHIFT).
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   s_info        : T packed entries, lane j at [j*E_WIDTH +: E_WIDTH]
//   s_info_valid  : per-lane entry available
//   s_info_ready  : per-lane pop strobe (one-hot or zero)
//   in_finish     : upstream-finished pulse, captured sticky
//   cmd_*         : command beat stream (valid/ready)
//   drain_done    : finished, idle and every lane empty (registered)
//
// Handshake: a beat transfers on a cycle where cmd_valid && cmd_ready are both
// high; while cmd_valid is high and cmd_ready low every cmd_* field holds. A
// lane entry transfers on a cycle where s_info_valid[j] && s_info_ready[j].
// ---------------------------------------------------------------------------
module info_fdsti_blk_cmd_gen #(
   parameter int O_TAM_WIDTH   = 2,
   parameter int I_FDSSI_WIDTH = 12,
   parameter int I_SSI_WIDTH   = 8,
   parameter int I_STI_WIDTH   = 8,
   parameter int LWIDTH        = 32,
   parameter int AWIDTH        = 32,
   parameter int SEG_SHIFT     = 16,
   parameter int E_WIDTH       = I_FDSSI_WIDTH + I_SSI_WIDTH + I_STI_WIDTH + LWIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [E_WIDTH*(2**O_TAM_WIDTH)-1:0] s_info,
   input  logic [(2**O_TAM_WIDTH)-1:0]       s_info_valid,
   output logic [(2**O_TAM_WIDTH)-1:0]       s_info_ready,
   input  logic                              in_finish,
   output logic                              cmd_valid,
   input  logic                              cmd_ready,
   output logic [I_FDSSI_WIDTH-1:0]          cmd_fdssi,
   output logic [O_TAM_WIDTH-1:0]            cmd_tlane,
   output logic [AWIDTH-1:0]                 cmd_src,
   output logic [AWIDTH-1:0]                 cmd_dst,
   output logic                              cmd_last,
   output logic                              drain_done
);

   localparam int T = 2**O_TAM_WIDTH;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e                   state_q, state_d;
   logic [O_TAM_WIDTH-1:0]   rr_q, rr_d;
   logic                     finish_q, finish_d;
   logic [LWIDTH-1:0]        off_q, off_d;
   logic [LWIDTH-1:0]        len_q, len_d;
   logic                     cmd_valid_q, cmd_valid_d;
   logic [I_FDSSI_WIDTH-1:0] cmd_fdssi_q, cmd_fdssi_d;
   logic [O_TAM_WIDTH-1:0]   cmd_tlane_q, cmd_tlane_d;
   logic [AWIDTH-1:0]        cmd_src_q, cmd_src_d;
   logic [AWIDTH-1:0]        cmd_dst_q, cmd_dst_d;
   logic                     cmd_last_q, cmd_last_d;
   logic                     drain_q, drain_d;

   // Round-robin search and the selected lane's entry fields
   logic                     grant_vld;
   logic [O_TAM_WIDTH-1:0]   grant_idx;
   logic [O_TAM_WIDTH-1:0]   cand_idx;
   logic [E_WIDTH-1:0]       sel_entry;
   logic [LWIDTH-1:0]        sel_len;
   logic [I_STI_WIDTH-1:0]   sel_sti;
   logic [I_SSI_WIDTH-1:0]   sel_ssi;
   logic [I_FDSSI_WIDTH-1:0] sel_fdssi;
   logic                     pop;
   logic                     beat_xfer;
   logic [LWIDTH-1:0]        off_nxt;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_q;
      cand_idx  = rr_q;
      for (int i = 0; i < T; i++) begin
         // Lane index arithmetic wraps at T for free in O_TAM_WIDTH bits
         cand_idx = rr_q + O_TAM_WIDTH'(i);
         if (!grant_vld && s_info_valid[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   assign sel_entry = s_info[grant_idx*E_WIDTH +: E_WIDTH];
   assign sel_len   = sel_entry[LWIDTH-1:0];
   assign sel_sti   = sel_entry[LWIDTH +: I_STI_WIDTH];
   assign sel_ssi   = sel_entry[LWIDTH+I_STI_WIDTH +: I_SSI_WIDTH];
   assign sel_fdssi = sel_entry[LWIDTH+I_STI_WIDTH+I_SSI_WIDTH +: I_FDSSI_WIDTH];

   // rst gates the pop so no entry is consumed while the block is held in reset
   assign pop       = (state_q == ST_IDLE) && grant_vld && !rst;
   assign beat_xfer = cmd_valid_q && cmd_ready;
   assign off_nxt   = off_q + LWIDTH'(1);

   // State register (all flops)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         finish_q    <= 1'b0;
         off_q       <= '0;
         len_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_fdssi_q <= '0;
         cmd_tlane_q <= '0;
         cmd_src_q   <= '0;
         cmd_dst_q   <= '0;
         cmd_last_q  <= 1'b0;
         drain_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         finish_q    <= finish_d;
         off_q       <= off_d;
         len_q       <= len_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_fdssi_q <= cmd_fdssi_d;
         cmd_tlane_q <= cmd_tlane_d;
         cmd_src_q   <= cmd_src_d;
         cmd_dst_q   <= cmd_dst_d;
         cmd_last_q  <= cmd_last_d;
         drain_q     <= drain_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pop && (sel_len != '0)) state_d = ST_RUN;
         ST_RUN:  if (beat_xfer && cmd_last_q) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      s_info_ready = '0;
      rr_d         = rr_q;
      off_d        = off_q;
      len_d        = len_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_fdssi_d  = cmd_fdssi_q;
      cmd_tlane_d  = cmd_tlane_q;
      cmd_src_d    = cmd_src_q;
      cmd_dst_d    = cmd_dst_q;
      cmd_last_d   = cmd_last_q;
      finish_d     = finish_q | in_finish;
      drain_d      = finish_q && (state_q == ST_IDLE) && (s_info_valid == '0);

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               s_info_ready[grant_idx] = 1'b1;
               rr_d = grant_idx + O_TAM_WIDTH'(1);
               // A zero-length entry is consumed without producing a beat
               if (sel_len != '0) begin
                  len_d       = sel_len;
                  off_d       = '0;
                  cmd_valid_d = 1'b1;
                  cmd_fdssi_d = sel_fdssi;
                  cmd_tlane_d = grant_idx;
                  cmd_src_d   = AWIDTH'(sel_ssi) << SEG_SHIFT;
                  cmd_dst_d   = AWIDTH'(sel_sti) << SEG_SHIFT;
                  cmd_last_d  = (sel_len == LWIDTH'(1));
               end
            end
         end
         ST_RUN: begin
            if (beat_xfer) begin
               if (cmd_last_q) begin
                  cmd_valid_d = 1'b0;
                  cmd_last_d  = 1'b0;
                  off_d       = '0;
               end else begin
                  // base + off advances by one per beat, so the addresses
                  // simply increment (wrapping modulo 2**AWIDTH)
                  off_d      = off_nxt;
                  cmd_src_d  = cmd_src_q + AWIDTH'(1);
                  cmd_dst_d  = cmd_dst_q + AWIDTH'(1);
                  cmd_last_d = (off_nxt == (len_q - LWIDTH'(1)));
               end
            end
         end
         default: ;
      endcase
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_fdssi  = cmd_fdssi_q;
   assign cmd_tlane  = cmd_tlane_q;
   assign cmd_src    = cmd_src_q;
   assign cmd_dst    = cmd_dst_q;
   assign cmd_last   = cmd_last_q;
   assign drain_done = drain_q;

endmodule

// File: tb/tb_info_fdsti_blk_cmd_gen.sv
module tb_info_fdsti_blk_cmd_gen;

   localparam int OTW = 2;
   localparam int T   = 4;
   localparam int FW  = 12;
   localparam int SW  = 8;
   localparam int TW  = 8;
   localparam int LW  = 32;
   localparam int AW  = 32;
   localparam int EW  = FW + SW + TW + LW;
   localparam int BW  = FW + OTW + AW + AW + 1;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rst;
   logic [EW*T-1:0] s_info;
   logic [T-1:0]    s_info_valid;
   logic [T-1:0]    s_info_ready;
   logic            in_finish;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [FW-1:0]   cmd_fdssi;
   logic [OTW-1:0]  cmd_tlane;
   logic [AW-1:0]   cmd_src;
   logic [AW-1:0]   cmd_dst;
   logic            cmd_last;
   logic            drain_done;

   always #5 clk = ~clk;

   info_fdsti_blk_cmd_gen dut (
      .clk          (clk),
      .rst          (rst),
      .s_info       (s_info),
      .s_info_valid (s_info_valid),
      .s_info_ready (s_info_ready),
      .in_finish    (in_finish),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_fdssi    (cmd_fdssi),
      .cmd_tlane    (cmd_tlane),
      .cmd_src      (cmd_src),
      .cmd_dst      (cmd_dst),
      .cmd_last     (cmd_last),
      .drain_done   (drain_done)
   );

   // ---------------- scoreboard state ----------------
   int             checks = 0;
   int             errors = 0;
   int             beat_cnt = 0;
   int             pop_cnt = 0;
   logic [BW-1:0]  exp_q[$];
   logic [OTW-1:0] pop_exp_q[$];
   logic [EW-1:0]  fifo_q[T][$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic logic [EW-1:0] mk_entry(input int fd, input int ssi, input int sti, input int len);
      return {FW'(fd), SW'(ssi), TW'(sti), LW'(len)};
   endfunction

   task automatic push_entry(input int lane, input logic [EW-1:0] e);
      fifo_q[lane].push_back(e);
   endtask

   task automatic exp_beat(input int fd, input int lane, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic last);
      exp_q.push_back({FW'(fd), OTW'(lane), src, dst, last});
   endtask

   // Expected pop of one lane plus its beat sequence (segment base + offset)
   task automatic expect_entry(input int lane, input int fd, input int ssi, input int sti, input int len);
      logic [AW-1:0] sb;
      logic [AW-1:0] tb;
      pop_exp_q.push_back(OTW'(lane));
      sb = AW'(ssi) << 16;
      tb = AW'(sti) << 16;
      for (int o = 0; o < len; o++)
         exp_beat(fd, lane, sb + AW'(o), tb + AW'(o), (o == len - 1));
   endtask

   // ---------------- lane FIFO model ----------------
   // Pops seen before the edge are applied just after it; the head entry and
   // valid are refreshed at the same point so pushes made at posedge+1 show up.
   logic [T-1:0] popm;
   initial begin
      s_info       = '0;
      s_info_valid = '0;
      forever begin
         @(negedge clk);
         popm = rst ? '0 : (s_info_ready & s_info_valid);
         @(posedge clk);
         #2;
         for (int j = 0; j < T; j++) begin
            if (popm[j] && fifo_q[j].size() != 0) void'(fifo_q[j].pop_front());
            s_info_valid[j] = (fifo_q[j].size() != 0);
            s_info[j*EW +: EW] = (fifo_q[j].size() != 0) ? fifo_q[j][0] : '0;
         end
      end
   end

   // ---------------- monitor ----------------
   logic           stalled = 1'b0;
   logic           lat_pend = 1'b0;
   logic [BW-1:0]  held;
   logic [BW-1:0]  cur_beat;
   logic [OTW-1:0] pop_lane;

   always @(negedge clk) begin
      if (rst) begin
         stalled  = 1'b0;
         lat_pend = 1'b0;
      end else begin
         cur_beat = {cmd_fdssi, cmd_tlane, cmd_src, cmd_dst, cmd_last};
         if (lat_pend) check("first_beat_latency", cmd_valid, 1'b1);
         lat_pend = 1'b0;
         if (s_info_ready != '0) begin
            check("ready_onehot", $onehot(s_info_ready), 1'b1);
            check("ready_with_valid", |(s_info_ready & s_info_valid), 1'b1);
            pop_lane = '0;
            for (int j = 0; j < T; j++) if (s_info_ready[j]) pop_lane = OTW'(j);
            if (pop_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_lane: got unexpected pop of lane %0d", pop_lane);
            end else begin
               check("pop_lane", pop_lane, pop_exp_q.pop_front());
            end
            pop_cnt++;
            lat_pend = (s_info[pop_lane*EW +: LW] != '0);
         end
         if (cmd_valid) check("ready_low_in_run", s_info_ready, '0);
         if (stalled) begin
            check("stall_valid_held", cmd_valid, 1'b1);
            check("stall_fields_held", cur_beat, held);
         end
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat: got unexpected beat %0h", cur_beat);
            end else begin
               check("beat", cur_beat, exp_q.pop_front());
            end
            beat_cnt++;
         end
         stalled = cmd_valid && !cmd_ready;
         held    = cur_beat;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drained(input string name, input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || pop_exp_q.size() != 0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(name, (exp_q.size() == 0 && pop_exp_q.size() == 0), 1'b1);
   endtask

   task automatic wait_beats(input string name, input int target, input int budget);
      int k = 0;
      while (beat_cnt < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(name, (beat_cnt >= target), 1'b1);
   endtask

   task automatic wait_pop(input string name, input int target, input int budget);
      int k = 0;
      while (pop_cnt < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(name, (pop_cnt >= target), 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int base;

   initial begin
      rst       = 1'b1;
      cmd_ready = 1'b0;
      in_finish = 1'b0;
      wait_cycles(1);

      // Test 1 entry is queued while reset is still held: no pop may happen yet
      push_entry(2, mk_entry(5, 1, 3, 3));
      wait_cycles(2);
      check("reset_outputs",
            {cmd_valid, s_info_ready, drain_done, cmd_last, cmd_fdssi, cmd_tlane, cmd_src, cmd_dst},
            '0);
      check("reset_lane_valid_seen", s_info_valid, 4'b0100);

      // Test 1: single lane-2 entry, three beats
      pop_exp_q.push_back(2'd2);
      exp_beat(5, 2, 32'h0001_0000, 32'h0003_0000, 1'b0);
      exp_beat(5, 2, 32'h0001_0001, 32'h0003_0001, 1'b0);
      exp_beat(5, 2, 32'h0001_0002, 32'h0003_0002, 1'b1);
      cmd_ready = 1'b1;
      rst       = 1'b0;
      wait_drained("t1_drain", 50);

      // Test 2: lanes 0,1,3 loaded twice; round robin from pointer 0
      do_reset();
      for (int r = 0; r < 2; r++) begin
         push_entry(0, mk_entry(16 + r*4 + 0, r*4 + 0, 8'h80, 1));
         push_entry(1, mk_entry(16 + r*4 + 1, r*4 + 1, 8'h81, 1));
         push_entry(3, mk_entry(16 + r*4 + 3, r*4 + 3, 8'h83, 1));
      end
      for (int r = 0; r < 2; r++) begin
         expect_entry(0, 16 + r*4 + 0, r*4 + 0, 8'h80, 1);
         expect_entry(1, 16 + r*4 + 1, r*4 + 1, 8'h81, 1);
         expect_entry(3, 16 + r*4 + 3, r*4 + 3, 8'h83, 1);
      end
      wait_drained("t2_drain", 100);

      // Test 3: zero-length entry on lane 1 is popped but emits nothing
      base = beat_cnt;
      push_entry(1, mk_entry(9, 9, 9, 0));
      pop_exp_q.push_back(2'd1);
      wait_drained("t3_drain", 20);
      wait_cycles(5);
      check("len0_no_beat", beat_cnt, base);
      check("len0_idle_no_valid", cmd_valid, 1'b0);

      // Test 4: LEN=4 with random back-pressure on lane 2
      base = beat_cnt;
      cmd_ready = 1'b0;
      push_entry(2, mk_entry(7, 8'h12, 8'h34, 4));
      expect_entry(2, 7, 8'h12, 8'h34, 4);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
         cmd_ready = 1'($urandom_range(0, 1));
      end
      cmd_ready = 1'b1;
      wait_drained("t4_drain", 20);
      check("t4_handshakes", beat_cnt - base, 4);

      // Test 5: in_finish during a LEN=2 entry on lane 3
      base = beat_cnt;
      push_entry(3, mk_entry(9, 2, 4, 2));
      expect_entry(3, 9, 2, 4, 2);
      wait_pop("t5_pop", pop_cnt + 1, 20);
      in_finish = 1'b1;
      @(posedge clk);
      #1;
      in_finish = 1'b0;
      @(negedge clk);
      check("drain_low_in_run", drain_done, 1'b0);
      wait_beats("t5_beats", base + 2, 20);
      @(negedge clk);
      check("drain_lag_after_last", drain_done, 1'b0);
      @(negedge clk);
      check("drain_set", drain_done, 1'b1);
      // New work must pull drain_done back down
      @(posedge clk);
      #1;
      push_entry(0, mk_entry(1, 5, 6, 1));
      expect_entry(0, 1, 5, 6, 1);
      @(negedge clk);
      @(negedge clk);
      check("drain_drops_on_valid", drain_done, 1'b0);
      wait_drained("t5_drain", 20);

      // Test 6: reset in the middle of a LEN=5 entry on lane 1
      base = beat_cnt;
      push_entry(1, mk_entry(10, 3, 7, 5));
      expect_entry(1, 10, 3, 7, 5);
      wait_beats("t6_first_beat", base + 1, 20);
      check("t6_running_before_rst", cmd_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_outputs",
            {cmd_valid, s_info_ready, cmd_last, cmd_fdssi, cmd_tlane, cmd_src, cmd_dst},
            '0);
      exp_q.delete();
      pop_exp_q.delete();
      wait_cycles(2);
      rst = 1'b0;
      // Pointer back at 0: lane 1 must win over lane 3, restarting at offset 0
      push_entry(3, mk_entry(11, 8, 9, 1));
      push_entry(1, mk_entry(12, 10, 11, 2));
      expect_entry(1, 12, 10, 11, 2);
      expect_entry(3, 11, 8, 9, 1);
      wait_drained("t6_drain", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
